// File: rtl/sequenciador_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : sequenciador_multiciclo
// Purpose  : Multicycle control sequencer for the single-issue RISC-V
//            datapath. It steps IF/ID/EX/MEM/WB/AUX/SUMPC and skips the phases
//            each instruction class does not use. It waits on mem_ready in
//            MEM and halts in FIM when it decodes an all-zero instruction.
// Options  : define SEQ_PERF_CNT_EN to build the ciclos/instr_ret counters;
//            without it both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sequenciador_multiciclo #(
  parameter int AUX_CYCLES   = 3,    // delay cycles before SUMPC, 0..15
  parameter int CNT_W        = 32,   // performance counter width
  parameter bit HALT_ON_ZERO = 1'b1  // all-zero instruction halts in ID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      instrucao,
  input  logic             mem_ready,
  output logic [3:0]       estado,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] ciclos,
  output logic [CNT_W-1:0] instr_ret
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EX    = 4'd2,
    S_MEM   = 4'd3,
    S_WB    = 4'd4,
    S_AUX   = 4'd5,
    S_SUMPC = 4'd8,
    S_FIM   = 4'd9,
    S_IDLE  = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_FULL   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_ALU    = 3'd4
  } class_t;

  localparam logic [3:0] AUX_INIT   = 4'(AUX_CYCLES);
  localparam bit         AUX_BYPASS = (AUX_CYCLES == 0);
  // Where the FSM goes once the last active phase of an instruction is done
  localparam state_t     POST_STATE = AUX_BYPASS ? S_SUMPC : S_AUX;

  state_t     state_q, state_d;
  class_t     class_q, class_d;
  logic [3:0] aux_cnt_q, aux_cnt_d;
  logic       enter_post;

  function automatic class_t decode_class(input logic [6:0] opcode);
    case (opcode)
      7'b0000011:          decode_class = CLS_LOAD;
      7'b0100011:          decode_class = CLS_STORE;
      7'b1100011:          decode_class = CLS_BRANCH;
      7'b0110011,
      7'b0010011:          decode_class = CLS_ALU;
      default:             decode_class = CLS_FULL;
    endcase
  endfunction

  // Next-state, class latch and AUX down-counter
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    aux_cnt_d  = aux_cnt_q;
    enter_post = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_IF;
      S_IF:    state_d = S_ID;
      S_ID: begin
        class_d = decode_class(instrucao[6:0]);
        if (HALT_ON_ZERO && (instrucao == 32'd0)) state_d = S_FIM;
        else                                      state_d = S_EX;
      end
      S_EX: begin
        case (class_q)
          CLS_BRANCH: enter_post = 1'b1;
          CLS_ALU:    state_d = S_WB;
          default:    state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (class_q == CLS_STORE) enter_post = 1'b1;
          else                      state_d = S_WB;
        end
      end
      S_WB:    enter_post = 1'b1;
      S_AUX: begin
        if (aux_cnt_q <= 4'd1) state_d = S_SUMPC;
        else                   aux_cnt_d = aux_cnt_q - 4'd1;
      end
      S_SUMPC: state_d = S_IF;
      S_FIM:   state_d = S_FIM;
      default: state_d = S_IDLE;
    endcase
    // The counter is loaded once on entry; AUX then counts it down to 1
    if (enter_post) begin
      state_d = POST_STATE;
      if (!AUX_BYPASS) aux_cnt_d = AUX_INIT;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      class_q   <= CLS_FULL;
      aux_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      aux_cnt_q <= aux_cnt_d;
    end
  end

  // Strobes are pure decodes of the state register
  assign estado = state_q;
  assign if_en  = (state_q == S_IF);
  assign id_en  = (state_q == S_ID);
  assign ex_en  = (state_q == S_EX);
  assign mem_en = (state_q == S_MEM);
  assign wb_en  = (state_q == S_WB);
  assign pc_en  = (state_q == S_SUMPC);
  assign halted = (state_q == S_FIM);
  assign busy   = (state_q != S_IDLE) && (state_q != S_FIM);

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] ciclos_q, ciclos_d;
  logic [CNT_W-1:0] instr_ret_q, instr_ret_d;

  // Busy-cycle and retired-instruction counters, wrapping naturally
  always_comb begin
    ciclos_d    = ciclos_q;
    instr_ret_d = instr_ret_q;
    if (busy)  ciclos_d    = ciclos_q + CNT_W'(1);
    if (pc_en) instr_ret_d = instr_ret_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ciclos_q    <= '0;
      instr_ret_q <= '0;
    end else begin
      ciclos_q    <= ciclos_d;
      instr_ret_q <= instr_ret_d;
    end
  end

  assign ciclos    = ciclos_q;
  assign instr_ret = instr_ret_q;
`else
  assign ciclos    = '0;
  assign instr_ret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequenciador_multiciclo
// Purpose  : Directed self-checking bench for sequenciador_multiciclo. It uses
//            a default instance (AUX=3, CNT_W=32) and a second instance
//            (AUX=0, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequenciador_multiciclo;

  localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EX = 4'd2, ST_MEM = 4'd3,
                         ST_WB = 4'd4, ST_AUX = 4'd5, ST_SUMPC = 4'd8,
                         ST_FIM = 4'd9, ST_IDLE = 4'd10;

  localparam logic [31:0] I_LW   = 32'h0000_2083;
  localparam logic [31:0] I_SW   = 32'h0010_2023;
  localparam logic [31:0] I_SUB  = 32'h4020_80b3;
  localparam logic [31:0] I_BEQ  = 32'h0020_8063;
  localparam logic [31:0] I_ADDI = 32'h0010_0093;

  int checks   = 0;
  int failures = 0;
  bit perf;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready;
  logic [31:0] instrucao;
  logic [3:0]  estado;
  logic        if_en, id_en, ex_en, mem_en, wb_en, pc_en, busy, halted;
  logic [31:0] ciclos, instr_ret;

  logic        rst2, start2, mem_ready2;
  logic [31:0] instrucao2;
  logic [3:0]  estado2;
  logic        if_en2, id_en2, ex_en2, mem_en2, wb_en2, pc_en2, busy2, halted2;
  logic [3:0]  ciclos2, instr_ret2;

  always #5 clk = ~clk;

  sequenciador_multiciclo dut (
    .clk(clk), .rst(rst), .start(start), .instrucao(instrucao), .mem_ready(mem_ready),
    .estado(estado), .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .wb_en(wb_en), .pc_en(pc_en), .busy(busy), .halted(halted),
    .ciclos(ciclos), .instr_ret(instr_ret)
  );

  sequenciador_multiciclo #(.AUX_CYCLES(0), .CNT_W(4), .HALT_ON_ZERO(1'b1)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .instrucao(instrucao2), .mem_ready(mem_ready2),
    .estado(estado2), .if_en(if_en2), .id_en(id_en2), .ex_en(ex_en2), .mem_en(mem_en2),
    .wb_en(wb_en2), .pc_en(pc_en2), .busy(busy2), .halted(halted2),
    .ciclos(ciclos2), .instr_ret(instr_ret2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {if,id,ex,mem,wb,pc,busy,halted} for a given state
  function automatic logic [7:0] exp_strobes(input logic [3:0] s);
    exp_strobes = {s == ST_IF, s == ST_ID, s == ST_EX, s == ST_MEM, s == ST_WB,
                   s == ST_SUMPC, (s != ST_IDLE) && (s != ST_FIM), s == ST_FIM};
  endfunction

  function automatic logic [7:0] obs_strobes();
    obs_strobes = {if_en, id_en, ex_en, mem_en, wb_en, pc_en, busy, halted};
  endfunction

  // Runs one instruction from IF through SUMPC on the default instance and
  // checks the state and strobes of every cycle
  task automatic run_instr(input logic [31:0] ins, input bit has_mem, input bit has_wb,
                           input int wait_cyc, input string tag);
    logic [3:0] exp_q[$];
    int mem_cnt = 0;
    exp_q.push_back(ST_IF);
    exp_q.push_back(ST_ID);
    exp_q.push_back(ST_EX);
    if (has_mem) repeat (wait_cyc + 1) exp_q.push_back(ST_MEM);
    if (has_wb) exp_q.push_back(ST_WB);
    repeat (3) exp_q.push_back(ST_AUX);
    exp_q.push_back(ST_SUMPC);
    instrucao = ins;
    mem_ready = (wait_cyc == 0);
    foreach (exp_q[i]) begin
      check($sformatf("%s_state%0d", tag, i), 32'(estado), 32'(exp_q[i]));
      check($sformatf("%s_strobe%0d", tag, i), 32'(obs_strobes()), 32'(exp_strobes(exp_q[i])));
      if (exp_q[i] == ST_MEM) begin
        mem_cnt++;
        mem_ready = (mem_cnt > wait_cyc);
      end
      tick();
    end
    mem_ready = 1'b1;
    check($sformatf("%s_next_if", tag), 32'(estado), 32'(ST_IF));
  endtask

  initial begin
`ifdef SEQ_PERF_CNT_EN
    perf = 1'b1;
`else
    perf = 1'b0;
`endif
    rst = 1'b1; start = 1'b1; instrucao = 32'd0; mem_ready = 1'b1;
    rst2 = 1'b1; start2 = 1'b0; instrucao2 = I_BEQ; mem_ready2 = 1'b1;
    #12;

    // Reset state with start held high
    check("rst_estado", 32'(estado), 32'(ST_IDLE));
    check("rst_strobes", 32'(obs_strobes()), 32'd0);
    check("rst_ciclos", ciclos, 32'd0);
    check("rst_instr_ret", instr_ret, 32'd0);

    // Release reset; start already high gives IF on the next edge
    rst = 1'b0;
    tick();
    start = 1'b0;
    check("start_if_en", 32'(if_en), 32'd1);

    // Class sequencing with AUX=3
    run_instr(I_LW,  1'b1, 1'b1, 0, "lw");
    run_instr(I_SW,  1'b1, 1'b0, 0, "sw");
    run_instr(I_SUB, 1'b0, 1'b1, 0, "sub");
    run_instr(I_BEQ, 1'b0, 1'b0, 0, "beq");
    check("seq_ciclos", ciclos, perf ? 32'd32 : 32'd0);
    check("seq_instr_ret", instr_ret, perf ? 32'd4 : 32'd0);

    // Load with four wait cycles: 13 cycles in total
    run_instr(I_LW, 1'b1, 1'b1, 4, "lw_wait");
    check("wait_ciclos", ciclos, perf ? 32'd45 : 32'd0);
    check("wait_instr_ret", instr_ret, perf ? 32'd5 : 32'd0);

    // Mid-op reset during AUX of an addi
    instrucao = I_ADDI;
    tick(); tick(); tick(); tick();
    check("addi_in_aux", 32'(estado), 32'(ST_AUX));
    #2 rst = 1'b1;
    #1;
    check("midrst_estado", 32'(estado), 32'(ST_IDLE));
    check("midrst_ciclos", ciclos, 32'd0);
    check("midrst_instr_ret", instr_ret, 32'd0);
    check("midrst_pc_en", 32'(pc_en), 32'd0);
    tick();
    check("midrst_hold_pc_en", 32'(pc_en), 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("midrst_idle_estado", 32'(estado), 32'(ST_IDLE));
    check("midrst_idle_pc_en", 32'(pc_en), 32'd0);

    // Halt on zero instruction
    start = 1'b1;
    tick();
    start = 1'b0;
    instrucao = 32'd0;
    check("halt_if", 32'(estado), 32'(ST_IF));
    tick();
    check("halt_id", 32'(estado), 32'(ST_ID));
    tick();
    check("halt_fim", 32'(estado), 32'(ST_FIM));
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    check("halt_stays", 32'(estado), 32'(ST_FIM));
    check("halt_ciclos", ciclos, perf ? 32'd2 : 32'd0);
    check("halt_instr_ret", instr_ret, 32'd0);

    // AUX=0, CNT_W=4: twenty branches of four cycles each
    rst2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int b = 0; b < 20; b++) begin
      check($sformatf("br%0d_if", b), 32'(estado2), 32'(ST_IF));
      tick();
      check($sformatf("br%0d_id", b), 32'(estado2), 32'(ST_ID));
      tick();
      check($sformatf("br%0d_ex", b), 32'(estado2), 32'(ST_EX));
      tick();
      check($sformatf("br%0d_sumpc", b), 32'(estado2), 32'(ST_SUMPC));
      check($sformatf("br%0d_pc_en", b), 32'(pc_en2), 32'd1);
      tick();
    end
    check("br_instr_ret_wrap", 32'(instr_ret2), perf ? 32'd4 : 32'd0);
    check("br_ciclos_wrap", 32'(ciclos2), 32'd0);
    tick();
    check("br_ciclos_plus1", 32'(ciclos2), perf ? 32'd1 : 32'd0);
    check("br_estado_id", 32'(estado2), 32'(ST_ID));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sequenciador_multiciclo.md
# sequenciador_multiciclo

Parametrised multicycle control sequencer for the single-issue RISC-V datapath (lw, sw, sub, xor, addi, srl, beq). It replaces the fixed IF→ID→EX→MEM→WB→AUX1..3→SUMPC loop with a synthesizable FSM. The FSM adds a reset, a start handshake, a memory-ready wait and a configurable delay-phase count. It skips phases that each instruction class does not use, and halts cleanly instead of calling `$finish`. It drives per-phase enable strobes into the fetch, decode, register, ALU, memory and PC stages.

## Interface
- `AUX_CYCLES`, default 3: number of delay cycles between the last active phase and SUMPC; legal range 0..15.
- `CNT_W`, default 32: width of the performance counters.
- `HALT_ON_ZERO`, default 1: if 1, an all-zero instruction in ID ends execution. If 0, it is executed as a full sequence (treated as unknown opcode).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  leaves IDLE; sampled only in IDLE.
- `instrucao`  in  32  fetched instruction; sampled only in ID.
- `mem_ready`  in  1  memory handshake; MEM is held while this input is low.
- `estado`  out  4  current state encoding.
- `if_en`, `id_en`, `ex_en`, `mem_en`, `wb_en`  out  1 each  phase strobe; high exactly while in the matching state.
- `pc_en`  out  1  high exactly while in SUMPC; the PC update strobe.
- `busy`  out  1  high in every state except IDLE and FIM.
- `halted`  out  1  high in FIM.
- `ciclos`  out  CNT_W  busy-cycle counter.
- `instr_ret`  out  CNT_W  retired-instruction counter.

## Operation
- State encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, AUX=5, SUMPC=8, FIM=9, IDLE=10. There is a single AUX state, iterated by an internal down-counter; AUX1..3 no longer exist as separate states.
- IDLE: moves to IF when `start`=1; otherwise stays in IDLE.
- IF → ID unconditionally.
- ID:
  - Latches an instruction class from `instrucao[6:0]`.
  - If `instrucao`==0 and HALT_ON_ZERO=1, the next state is FIM.
  - Otherwise the next state is EX.
- Instruction classes:
  - Load, opcode 0000011: EX→MEM→WB.
  - Store, opcode 0100011: EX→MEM, skips WB.
  - Branch, opcode 1100011: EX only, skips MEM and WB.
  - ALU, opcodes 0110011 and 0010011: EX→WB, skips MEM.
  - Any other opcode: full EX→MEM→WB sequence.
- MEM: stays in MEM while `mem_ready`=0 and advances on the first edge where `mem_ready`=1. There is no timeout.
- After the last active phase, the FSM loads the AUX counter with AUX_CYCLES and enters AUX.
  - AUX exits to SUMPC when the counter reaches 1.
  - If AUX_CYCLES=0, AUX is bypassed and the last active phase goes directly to SUMPC.
- SUMPC → IF, which starts the next instruction.
- FIM is terminal. It is left only by `rst`; `start` is ignored in FIM.
- All strobes and `busy`/`halted` are decoded combinationally from `estado` and are glitch-free with respect to `clk`.

## Timing
- Reset values: `estado`=IDLE (10), all strobes 0, `busy`=0, `halted`=0, `ciclos`=0, `instr_ret`=0, AUX counter 0, latched class = full.
- Asserting `rst` mid-instruction returns the FSM to IDLE asynchronously. No partial phase completes afterwards, and the counters clear.
- Cycles per instruction, from IF through SUMPC, with `mem_ready`=1:
  - Base: load 6+A, store 5+A, ALU 5+A, branch 4+A, where A = AUX_CYCLES.
  - With the default A=3: load 9, store 8, ALU 8, branch 7.
  - Each cycle `mem_ready` is held low adds exactly one cycle to load/store/unknown.
- `start` to first `if_en`: 1 cycle.
- Zero instruction in ID: FIM is reached on the next edge and `halted` rises 2 cycles after IF.
- `ciclos` increments on every edge where `busy`=1, including MEM wait cycles. It wraps modulo 2^CNT_W.
- `instr_ret` increments on each edge leaving SUMPC and wraps modulo 2^CNT_W.
- An instruction that halts in ID is not counted in `instr_ret`.

## Configuration
- `SEQ_PERF_CNT_EN` defined: `ciclos` and `instr_ret` are implemented as described above.
- `SEQ_PERF_CNT_EN` undefined: no counter registers are built, and `ciclos` and `instr_ret` are tied to 0. The ports remain present. FSM behaviour is identical.

## Test plan
- Reset/start: assert `rst` with `start`=1 → `estado`=10, all outputs 0. Release `rst` and pulse `start` → `if_en` high on the next cycle.
- Class sequencing with AUX=3: feed lw, sw, add, beq → state traces IF,ID,EX,MEM,WB,AUX×3,SUMPC (9), then 8, 8 and 7 cycles; `instr_ret`=4 and `ciclos`=32.
- Memory wait: lw with `mem_ready` low for 4 cycles → MEM is held for 5 cycles, and the instruction takes 13 cycles.
- Halt: `instrucao`=0 in ID → FIM next edge, `halted`=1, `busy`=0. `start` pulses are ignored, and the counters freeze.
- Mid-op reset: assert `rst` during AUX of an addi → immediate IDLE and counters 0. No `pc_en` pulse occurs.
- Parameters: AUX_CYCLES=0, CNT_W=4, 20 branches → each takes 4 cycles, and `instr_ret` wraps to 4. With `SEQ_PERF_CNT_EN` undefined, both counters read 0 throughout.
